sar_search: RTL and testbench



---
 rtl/sar_search.sv | 74 +++++++
 tb/tb_sar_search.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// sar_search: MSB-first successive-approximation search driving an external comparator.
// Define SAR_EARLY_EXIT_EN to finish as soon as the comparator reports equality.
module sar_search #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t state_q;
  logic [WIDTH-1:0] trial_q, trial_d, result_q;
  logic [IW-1:0] idx_q;
  logic busy_q, done_q, err_q, illegal, hit, stop;
  always_comb begin
    illegal = ({1'b0, cmp_gt} + {1'b0, cmp_lt} + {1'b0, cmp_eq}) != 2'd1;
    trial_d = trial_q & ~(WIDTH'(cmp_gt) << idx_q);
`ifdef SAR_EARLY_EXIT_EN
    hit = cmp_eq;
`else
    hit = 1'b0;
`endif
    stop = illegal || hit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= CMP;
          trial_q <= {1'b1, {(WIDTH-1){1'b0}}};
          idx_q   <= IW'(WIDTH-1);
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
        end
        CMP: if (stop || idx_q == '0) begin
          // Aborted or early-exit searches report the trial that was just judged
          state_q  <= DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          err_q    <= illegal;
          trial_q  <= stop ? trial_q : trial_d;
          result_q <= stop ? trial_q : trial_d;
        end else begin
          trial_q <= trial_d | (WIDTH'(1) << (idx_q - IW'(1)));
          idx_q   <= idx_q - IW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed checks of sar_search (WIDTH=3) against a behavioral comparator.
module tb_sar_search;
  localparam int W = 3;
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, force_ill = 1'b0;
  logic [W-1:0] target = '0, trial, result;
  logic cmp_gt, cmp_lt, cmp_eq, busy, done, err;
  int checks = 0, fails = 0;
  logic [W-1:0] tr [8];
  int ntr;
  int k_ee [8] = '{3, 3, 2, 3, 1, 3, 2, 3};
  always #5 clk = ~clk;
  assign cmp_gt = force_ill | (trial > target);
  assign cmp_lt = force_ill | (trial < target);
  assign cmp_eq = trial == target;
  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trial(trial),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .busy(busy), .done(done), .result(result), .err(err)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input bit hold, output int n, output int tot);
    n = 0;
    tot = 0;
    ntr = 0;
    while (!busy && tot < 20) begin
      step();
      tot++;
    end
    if (!hold) start = 1'b0;
    while (!done && n < 20) begin
      if (ntr < 8) begin
        tr[ntr] = trial;
        ntr++;
      end
      step();
      n++;
    end
    tot += n;
    if (n >= 20) n = -1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({trial, result, busy, done, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0", {trial, result, busy, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_search(input logic [W-1:0] t, input logic [3*W-1:0] tv, input int en);
    int n, tot;
    @(negedge clk);
    target = t;
    start = 1'b1;
    wait_done(1'b0, n, tot);
    checks++;
    if (n !== en) begin fails++; $display("FAIL cmp_cycles t=%0d: got %0d expected %0d", t, n, en); end
    checks++;
    if (tot !== en + 1) begin fails++; $display("FAIL start_to_done t=%0d: got %0d expected %0d", t, tot, en + 1); end
    checks++;
    if (result !== t) begin fails++; $display("FAIL result t=%0d: got %b expected %b", t, result, t); end
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL err t=%0d: got %b expected 0", t, err); end
    checks++;
    if (ntr !== en) begin fails++; $display("FAIL trial_count t=%0d: got %0d expected %0d", t, ntr, en); end
    for (int i = 0; i < en; i++) begin
      checks++;
      if (tr[i] !== tv[3*W-1-W*i -: W]) begin
        fails++;
        $display("FAIL trial%0d t=%0d: got %b expected %b", i, t, tr[i], tv[3*W-1-W*i -: W]);
      end
    end
    step();
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_pulse t=%0d: got %b expected 0", t, done); end
  endtask
  task automatic test_illegal();
    int n, tot;
    @(negedge clk);
    target = 3'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (trial !== 3'b110) begin fails++; $display("FAIL ill_trial: got %b expected 110", trial); end
    force_ill = 1'b1;
    step();
    force_ill = 1'b0;
    checks++;
    if ({done, err, busy} !== 3'b110) begin fails++; $display("FAIL ill_flags done/err/busy: got %b expected 110", {done, err, busy}); end
    checks++;
    if (result !== 3'b110) begin fails++; $display("FAIL ill_result: got %b expected 110", result); end
    step();
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL ill_err_held: got %b expected 1", err); end
    @(negedge clk);
    target = 3'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, err} !== 2'b10) begin fails++; $display("FAIL ill_err_clear busy/err: got %b expected 10", {busy, err}); end
    wait_done(1'b0, n, tot);
    checks++;
    if (result !== 3'd2 || err !== 1'b0) begin fails++; $display("FAIL ill_recover result/err: got %b/%b expected 010/0", result, err); end
    step();
  endtask
  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clk);
    target = 3'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({trial, result, busy, done, err} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %b expected 0", {trial, result, busy, done, err});
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin @(negedge clk); rst_n = 1'b1; end
      step();
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_mid_no_done seen/busy: got %b/%b expected 0/0", seen, busy); end
  endtask
  task automatic test_ignored_start();
    logic [W-1:0] exp_tr [3] = '{3'b100, 3'b010, 3'b011};
    @(negedge clk);
    target = 3'd3;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (trial !== exp_tr[i] || busy !== 1'b1) begin
        fails++;
        $display("FAIL ignore_trial%0d trial/busy: got %b/%b expected %b/1", i, trial, busy, exp_tr[i]);
      end
    end
    start = 1'b0;
    step();
    checks++;
    if (done !== 1'b1 || result !== 3'd3) begin fails++; $display("FAIL ignore_done done/result: got %b/%b expected 1/011", done, result); end
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL ignore_no_relaunch: got busy %b expected 0", busy); end
  endtask
  task automatic test_back_to_back();
    int n, tot, en;
    @(negedge clk);
    start = 1'b1;
    for (int t = 0; t < 8; t++) begin
      target = W'(t);
      en = EE ? k_ee[t] : W;
      wait_done(1'b1, n, tot);
      checks++;
      if (result !== W'(t) || err !== 1'b0) begin fails++; $display("FAIL b2b_result t=%0d result/err: got %b/%b expected %b/0", t, result, err, W'(t)); end
      checks++;
      if (n !== en) begin fails++; $display("FAIL b2b_cycles t=%0d: got %0d expected %0d", t, n, en); end
      checks++;
      if (tot !== en + (t == 0 ? 1 : 2)) begin fails++; $display("FAIL b2b_period t=%0d: got %0d expected %0d", t, tot, en + (t == 0 ? 1 : 2)); end
    end
    start = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_stop: got busy %b expected 0", busy); end
  endtask
  initial begin
    test_reset();
    test_search(3'd5, {3'b100, 3'b110, 3'b101}, 3);
    test_search(3'd4, {3'b100, 3'b110, 3'b101}, EE ? 1 : 3);
    test_search(3'd0, {3'b100, 3'b010, 3'b001}, 3);
    test_search(3'd7, {3'b100, 3'b110, 3'b111}, 3);
    test_illegal();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
